// File: rtl/phase_ctrl_pkg.sv
// Shared definitions for the phase broadcast sequencer: opcodes, FSM states,
// command/broadcast field positions and the broadcast word packer.
package phase_ctrl_pkg;

    typedef enum logic [7:0] {
        OPC_WRITE   = 8'h00,
        OPC_COMMIT  = 8'h01,
        OPC_ALL_OFF = 8'h02
    } opcode_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ARMED,
        ST_SWEEP,
        ST_OFF_SWEEP
    } state_e;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 24;
    localparam int unsigned EN_BIT  = 16;
    localparam int unsigned CH_MSB  = 15;
    localparam int unsigned CH_LSB  = 8;
    localparam int unsigned PH_MSB  = 7;
    localparam int unsigned PH_LSB  = 0;

    function automatic logic [31:0] pack_phase_word(input logic en,
                                                    input logic [7:0] ch,
                                                    input logic [7:0] ph);
        return {15'b0, en, ch, ph};
    endfunction

endpackage

// File: rtl/phase_shadow_ram.sv
// Shadow phase table: one write port, one synchronous read port, no reset.
module phase_shadow_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 9
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/phase_frame_sequencer.sv
// Buffers host phase writes and replays the whole table on the PWM period
// boundary after a commit; also provides an all-channels-off sweep for estop.
module phase_frame_sequencer
    import phase_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        estop,
    input  logic        period_start,
    output logic        phase_parse_en,
    output logic [31:0] phase_data,
    output logic        busy,
    output logic        cmd_err
);

    localparam int unsigned AW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [AW-1:0] LAST = AW'(NUM_CHANNELS - 1);
    localparam logic [8:0]    NCH  = 9'(NUM_CHANNELS);

    state_e        state;
    logic [AW-1:0] cnt;
    logic [8:0]    nxt9;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [8:0]    wr_data;
    logic [8:0]    rd_data;
    logic [7:0]    cmd_op;
    logic [7:0]    cmd_ch;
    logic [7:0]    cmd_ph;
    logic          cmd_en;
    logic          ch_ok;
    logic          accept;
    logic          unused_bits;

    function automatic logic [AW-1:0] wrap_idx(input logic [8:0] x);
        return (x >= NCH) ? '0 : x[AW-1:0];
    endfunction

    assign cmd_op      = s_data[OPC_MSB:OPC_LSB];
    assign cmd_en      = s_data[EN_BIT];
    assign cmd_ch      = s_data[CH_MSB:CH_LSB];
    assign cmd_ph      = s_data[PH_MSB:PH_LSB];
    assign unused_bits = ^s_data[23:17];

    assign ch_ok   = ({1'b0, cmd_ch} < NCH);
    assign s_ready = (state == ST_IDLE) && !estop;
    assign accept  = s_valid && s_ready;
    assign busy    = (state != ST_IDLE);
    assign nxt9    = 9'(cnt) + 9'd1;

    // Read address runs one entry ahead of the strobe being launched, so
    // rd_data already holds the entry to emit (or to rewrite) at each edge.
    always_comb begin
        rd_addr = '0;
        if (!(estop && state != ST_OFF_SWEEP && state != ST_INIT)) begin
            case (state)
                ST_ARMED:     rd_addr = period_start ? wrap_idx(9'd1) : '0;
                ST_SWEEP:     rd_addr = wrap_idx(9'(cnt) + 9'd2);
                ST_OFF_SWEEP: rd_addr = wrap_idx(nxt9);
                default:      rd_addr = '0;
            endcase
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cnt;
        wr_data = '0;
        case (state)
            ST_INIT: wr_en = 1'b1;
            ST_OFF_SWEEP: begin
                wr_en   = 1'b1;
                wr_data = {1'b0, rd_data[7:0]};
            end
            ST_IDLE: begin
                if (accept && cmd_op == OPC_WRITE && ch_ok) begin
                    wr_en   = 1'b1;
                    wr_addr = cmd_ch[AW-1:0];
                    wr_data = {cmd_en, cmd_ph};
                end
            end
            default: wr_en = 1'b0;
        endcase
    end

    phase_shadow_ram #(
        .DEPTH (NUM_CHANNELS),
        .AW    (AW),
        .DW    (9)
    ) u_shadow (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_INIT;
            cnt            <= '0;
            phase_parse_en <= 1'b0;
            phase_data     <= '0;
            cmd_err        <= 1'b0;
        end else begin
            phase_parse_en <= 1'b0;
            phase_data     <= '0;
            cmd_err        <= 1'b0;
            if (state == ST_INIT) begin
                // Table clear after reset; the RAM itself has no reset.
                if (cnt == LAST) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (estop && state != ST_OFF_SWEEP) begin
                state          <= ST_OFF_SWEEP;
                cnt            <= '0;
                phase_parse_en <= 1'b1;
                phase_data     <= pack_phase_word(1'b0, 8'h00, 8'h00);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            case (cmd_op)
                                OPC_WRITE:  cmd_err <= !ch_ok;
                                OPC_COMMIT: state   <= ST_ARMED;
                                OPC_ALL_OFF: begin
                                    state          <= ST_OFF_SWEEP;
                                    cnt            <= '0;
                                    phase_parse_en <= 1'b1;
                                    phase_data     <= pack_phase_word(1'b0, 8'h00, 8'h00);
                                end
                                default: cmd_err <= 1'b1;
                            endcase
                        end
                    end
                    ST_ARMED: begin
                        if (period_start) begin
                            state          <= ST_SWEEP;
                            cnt            <= '0;
                            phase_parse_en <= 1'b1;
                            phase_data     <= pack_phase_word(rd_data[8], 8'h00, rd_data[7:0]);
                        end
                    end
                    ST_SWEEP: begin
                        if (cnt == LAST) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt            <= cnt + 1'b1;
                            phase_parse_en <= 1'b1;
                            phase_data     <= pack_phase_word(rd_data[8], nxt9[7:0], rd_data[7:0]);
                        end
                    end
                    ST_OFF_SWEEP: begin
                        if (cnt == LAST) begin
                            cnt <= '0;
                            if (estop) begin
                                phase_parse_en <= 1'b1;
                                phase_data     <= pack_phase_word(1'b0, 8'h00, 8'h00);
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            cnt            <= cnt + 1'b1;
                            phase_parse_en <= 1'b1;
                            phase_data     <= pack_phase_word(1'b0, nxt9[7:0], 8'h00);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_frame_sequencer.sv
// Scoreboard bench for phase_frame_sequencer with four channels: stimulus
// pushes expected strobes and error pulses, a monitor pops and compares.
module tb_phase_frame_sequencer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        estop = 1'b0;
    logic        period_start = 1'b0;
    logic        s_ready;
    logic        phase_parse_en;
    logic [31:0] phase_data;
    logic        busy;
    logic        cmd_err;

    phase_frame_sequencer #(.NUM_CHANNELS(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .estop          (estop),
        .period_start   (period_start),
        .phase_parse_en (phase_parse_en),
        .phase_data     (phase_data),
        .busy           (busy),
        .cmd_err        (cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] w, output int t);
        s_data  = w;
        s_valid = 1'b1;
        chk("ready_at_cmd", 32'(s_ready), 32'd1);
        t = cyc + 1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic pulse(output int p);
        period_start = 1'b1;
        p = cyc + 1;
        @(posedge clk);
        #1;
        period_start = 1'b0;
    endtask

    task automatic push4(input int base, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        exp_q.push_back('{data: a, cyc: base});
        exp_q.push_back('{data: b, cyc: base + 1});
        exp_q.push_back('{data: c, cyc: base + 2});
        exp_q.push_back('{data: d, cyc: base + 3});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        int p;
        int d;
        exp_t e;
        int   ec;

        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    if (phase_parse_en === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_strobe: got %h at cycle %0d expected none", phase_data, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            chk("strobe_data", phase_data, e.data);
                            chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                        end
                    end
                    if (cmd_err === 1'b1) begin
                        if (err_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_cmd_err: got 1 at cycle %0d expected 0", cyc);
                        end else begin
                            ec = err_q.pop_front();
                            chk("cmd_err_cycle", 32'(cyc), 32'(ec));
                        end
                    end
                end
            end
        join_none

        // Reset and table clear: s_ready rises N edges after the last reset edge.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k <= N; k++) begin
            @(negedge clk);
            chk("reset_ready", 32'(s_ready), 32'(k >= N));
            chk("reset_busy", 32'(busy), 32'(k < N));
            if (k == 0)
                chk("reset_data", phase_data, 32'h0);
        end
        @(posedge clk);
        #1;

        // Write ch2, commit, sweep on a later period pulse.
        send(32'h0001_0280, t);
        send(32'h0100_0000, t);
        chk("commit_busy", 32'(busy), 32'd1);
        idle(10);
        pulse(p);
        push4(p, 32'h0000_0000, 32'h0000_0100, 32'h0001_0280, 32'h0000_0300);
        idle(4);
        chk("sweep_done_ready", 32'(s_ready), 32'd1);

        // Dropped commands: out-of-range channel and unknown opcode.
        send(32'h0001_0755, t);
        err_q.push_back(t);
        idle(1);
        send(32'h0500_0000, t);
        err_q.push_back(t);
        idle(1);

        // Period pulse in the commit acceptance cycle is ignored.
        s_data       = 32'h0100_0000;
        s_valid      = 1'b1;
        period_start = 1'b1;
        chk("ready_at_cmd", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid      = 1'b0;
        s_data       = '0;
        period_start = 1'b0;
        idle(5);
        chk("armed_busy", 32'(busy), 32'd1);
        chk("armed_not_ready", 32'(s_ready), 32'd0);
        pulse(p);
        push4(p, 32'h0000_0000, 32'h0000_0100, 32'h0001_0280, 32'h0000_0300);
        idle(4);

        // ALL_OFF disables everything but keeps phases.
        send(32'h0200_0000, t);
        push4(t, 32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300);
        idle(4);
        chk("all_off_done_ready", 32'(s_ready), 32'd1);
        send(32'h0100_0000, t);
        idle(2);
        pulse(p);
        push4(p, 32'h0000_0000, 32'h0000_0100, 32'h0000_0280, 32'h0000_0300);
        idle(4);

        // estop aborts a sweep before the third strobe.
        send(32'h0001_0011, t);
        send(32'h0000_0122, t);
        send(32'h0001_0280, t);
        send(32'h0100_0000, t);
        idle(2);
        pulse(p);
        exp_q.push_back('{data: 32'h0001_0011, cyc: p});
        exp_q.push_back('{data: 32'h0000_0122, cyc: p + 1});
        @(posedge clk);
        #1;
        estop = 1'b1;
        chk("estop_ready", 32'(s_ready), 32'd0);
        push4(p + 2, 32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300);
        @(posedge clk);
        #1;
        estop = 1'b0;
        idle(4);
        chk("estop_done_ready", 32'(s_ready), 32'd1);
        chk("estop_done_busy", 32'(busy), 32'd0);
        send(32'h0100_0000, t);
        idle(2);
        pulse(p);
        push4(p, 32'h0000_0011, 32'h0000_0122, 32'h0000_0280, 32'h0000_0300);
        idle(4);

        // estop held across a sweep boundary gives back-to-back off sweeps.
        estop = 1'b1;
        d = cyc;
        push4(d + 1, 32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300);
        push4(d + 5, 32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300);
        repeat (6) @(posedge clk);
        #1;
        chk("estop_hold_ready", 32'(s_ready), 32'd0);
        estop = 1'b0;
        idle(3);
        chk("estop_hold_done_ready", 32'(s_ready), 32'd1);

        idle(3);
        done = 1'b1;
        idle(2);
        chk("missing_strobes", 32'(exp_q.size()), 32'd0);
        chk("missing_cmd_errs", 32'(err_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_frame_sequencer.md
# phase_frame_sequencer

- Sits between the host command stream and the per-channel phase parsers; drives their shared `phase_parse_en`/`phase_data` broadcast bus.
- Buffers host phase writes in a shadow table.
- On commit, waits for the next PWM period boundary and replays the full table, one channel per cycle, so all transducers change phase in the same PWM period.
- Also supplies an immediate all-channels-off sweep for safety.

## Interface

**Parameters**

- `NUM_CHANNELS`, 64: number of parser channels; must be 1..256.

**Ports**

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_data` in 32: host command word. Fields:
  - [31:24] opcode: 0x00 WRITE, 0x01 COMMIT, 0x02 ALL_OFF.
  - [16] enable.
  - [15:8] channel.
  - [7:0] phase.
- `s_valid` in 1: command word valid.
- `s_ready` out 1: command accepted when `s_valid && s_ready`.
- `estop` in 1: level; forces an all-off sweep.
- `period_start` in 1: one-cycle pulse at PWM counter wrap.
- `phase_parse_en` out 1: broadcast strobe to parsers.
- `phase_data` out 32: broadcast word. Fields:
  - [31:17] zero.
  - [16] enable.
  - [15:8] channel.
  - [7:0] phase.
- `busy` out 1: high in any state other than IDLE.
- `cmd_err` out 1: one-cycle pulse when a command is dropped.

## Operation

- **Shadow table**
  - NUM_CHANNELS entries of {enable, phase[7:0]}; reset to all zero.
  - Persists across frames, so the host rewrites only changed channels.
- **States**
  - IDLE: `s_ready`=1.
  - ARMED: waiting for `period_start`; `s_ready`=0.
  - SWEEP: replay table; `s_ready`=0.
  - OFF_SWEEP: disable all; `s_ready`=0.
- **Commands in IDLE**
  - WRITE with channel < NUM_CHANNELS updates the shadow entry.
  - WRITE with channel >= NUM_CHANNELS is dropped and pulses `cmd_err`.
  - COMMIT: go to ARMED.
  - ALL_OFF: go to OFF_SWEEP.
  - Any other opcode is dropped and pulses `cmd_err`.
- **ARMED**: `period_start` takes the block to SWEEP.
- **SWEEP**
  - Index i = 0..NUM_CHANNELS-1, one per cycle.
  - Emits `phase_parse_en`=1, `phase_data`={15'b0, en[i], i[7:0], phase[i]}.
  - Returns to IDLE after the last index.
- **OFF_SWEEP**
  - Same ordering and length as SWEEP.
  - Emits enable=0, phase=0 for every index.
  - Clears every shadow enable bit; phases are kept.
  - Returns to IDLE.
- **`estop` priority**
  - While `estop`=1 in any state except OFF_SWEEP, the next state is OFF_SWEEP with index restarting at 0.
  - `estop` held high beyond one sweep causes back-to-back OFF_SWEEPs.
  - `s_ready`=0 while `estop`=1.
- `estop` during SWEEP aborts the sweep immediately. Channels already written keep the new phase; the OFF_SWEEP then disables everything.
- `period_start` outside ARMED is ignored. `period_start` in the same cycle a COMMIT is accepted does not count.

## Timing

- **Reset values**: state IDLE, `phase_parse_en`=0, `phase_data`=0, `busy`=0, `cmd_err`=0, shadow all zero, `s_ready`=1 in the first cycle after `rst` deasserts.
- **WRITE**: accepted at cycle t; shadow visible to a sweep from t+1.
- **COMMIT**: accepted at t; `busy`=1 from t+1.
- **SWEEP timing**
  - `period_start` sampled high in ARMED at cycle p.
  - `phase_parse_en` high for cycles p+1 .. p+NUM_CHANNELS.
  - Channel index equals cycle minus (p+1).
  - State is IDLE and `s_ready`=1 at p+NUM_CHANNELS+1.
- **OFF_SWEEP timing**: ALL_OFF accepted, or `estop` first high, at t; strobes at t+1 .. t+NUM_CHANNELS.
- **Outputs**: `phase_parse_en`/`phase_data` are registered outputs. Shadow reads are synchronous, so the read address is issued one cycle ahead (index 0 is presented in ARMED/IDLE).
- **Error pulse**: `cmd_err` is high exactly in the cycle after the offending acceptance.
- **Reset mid-sweep**: aborts at once; no further strobes; shadow cleared.

## Structure

- **Package `phase_ctrl_pkg`**:
  - opcode enum.
  - state enum.
  - field localparams (OPC_MSB/LSB, EN_BIT, CH_MSB/LSB, PH_MSB/LSB).
  - a function packing {en, ch, phase} into the 32-bit broadcast word.
- **Sub-module `phase_shadow_ram`**:
  - NUM_CHANNELS x 9 bits.
  - one write port, one synchronous read port.
  - synchronous clear is not required; the sequencer clears the table with a write sweep after reset.
  - `busy` stays high and `s_ready` low for those NUM_CHANNELS cycles.
  - This overrides the reset timing above: first `s_ready`=1 is at cycle NUM_CHANNELS+1 after `rst` deasserts.
  - Enable-bit clearing during OFF_SWEEP uses the same write port.

## Test plan

- **Reset init**: NUM_CHANNELS=4, release reset → `s_ready` rises at cycle 5; no `phase_parse_en`.
- **Write + commit + sweep**: WRITE ch2 en=1 ph=0x80, COMMIT, pulse `period_start` 10 cycles later → 4 strobes starting the next cycle: 0x00000000, 0x00000100, 0x00010280, 0x00000300.
- **Bad commands**: WRITE ch=7 (NUM_CHANNELS=4) and opcode 0x05 → each dropped; one `cmd_err` pulse each; the following sweep shows no change.
- **Ignored period pulse**: `period_start` in the COMMIT acceptance cycle → no sweep until the next pulse.
- **ALL_OFF**: after ch2 enabled, issue ALL_OFF → 4 strobes all with bit16=0 and phase=0. A later COMMIT + sweep shows ch2 en=0 ph=0x80.
- **`estop` abort**: `estop` at the third SWEEP strobe → strobes for ch0, ch1 (values), then OFF_SWEEP ch0..ch3 disabled; IDLE afterwards.
